oled_spi_driver: RTL and testbench
==================================

# oled_spi_driver

Parametrised SSD1306-class OLED driver: runs the panel power/reset sequence, sends a fixed init command list over a write-only 4-wire SPI, then streams a frame buffer to the panel on request or continuously. It adds a host write port into an internal frame RAM, a programmable SPI clock divider, a configurable panel geometry with a per-frame address window, and frame handshakes. It sits between the game logic, which draws into the frame RAM, and the display pins.

## Interface
- STARTUP_WAIT, 10000000: clk cycles per phase of the power-up reset sequence (three phases).
- CLK_DIV, 1: clk cycles per SPI half-period (≥1).
- COLS, 128: panel columns (≤128).
- PAGES, 8: panel pages of 8 rows (≤8).
- ADDR_W, 10: frame RAM address width; 2^ADDR_W ≥ COLS*PAGES.

- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- io_sclk  out  1  SPI clock; idles high.
- io_sdin  out  1  SPI data, MSB first.
- io_cs  out  1  chip select, active low.
- io_dc  out  1  0 = command byte, 1 = data byte.
- io_reset  out  1  panel reset, active low.
- wr_en  in  1  frame RAM write strobe.
- wr_addr  in  ADDR_W  byte address; addr = page*COLS + column.
- wr_data  in  8  byte (bit0 = top row of the page).
- refresh_req  in  1  request one frame transfer.
- continuous  in  1  1 = start frames back-to-back.
- busy  out  1  high whenever the FSM is not in IDLE.
- init_done  out  1  stays high once the init list has been sent.
- frame_done  out  1  one-cycle pulse after the last data byte of a frame.

## Operation
- Reset values (applied asynchronously): io_sclk=1, io_sdin=0, io_cs=1, io_dc=1, io_reset=1, busy=1, init_done=0, frame_done=0, pending=0. Counters are cleared and the FSM enters PWR_HI. Frame RAM contents are not cleared.
- Power-up sequence: PWR_HI (io_reset=1), then PWR_LO (io_reset=0), then PWR_HI2 (io_reset=1). Each phase lasts STARTUP_WAIT cycles, then the FSM moves to CMD_LOAD.
- Init list, 23 bytes, sent with dc=0: AE 81 7F A6 20 00 C8 40 A1 A8 (PAGES*8-1) D3 00 D5 80 D9 22 DB 20 8D 14 A4 AF. After AF, init_done is set and the FSM moves to IDLE.
- Byte transfer:
  - LOAD (1 cycle): latch the byte, drive dc, set io_cs=0.
  - SEND (16*CLK_DIV cycles): 8 bits. For each bit, io_sclk goes low and io_sdin updates for CLK_DIV cycles, then io_sclk goes high for CLK_DIV cycles.
  - GAP (1 cycle): io_cs=1, io_sclk=1.
- IDLE exit condition: refresh_req, pending, or continuous starts a frame.
- Frame transfer:
  - WINDOW phase, 6 bytes with dc=0: 21 00 (COLS-1) 22 00 (PAGES-1).
  - DATA phase: COLS*PAGES bytes from RAM addresses 0 up to COLS*PAGES-1, with dc=1.
  - Then frame_done pulses and the FSM returns to IDLE.
- refresh_req while busy sets pending. One level of pending only; further requests merge into it. pending clears when a frame starts.
- Frame RAM:
  - Dual-port.
  - Writes are accepted in every state, including reset sequence and init.
  - A read and a write to the same address in the same cycle returns the old data (read-first).
  - Writes during streaming may tear; an address already sent shows on the next frame.
  - wr_addr ≥ COLS*PAGES is ignored.
- continuous deasserted mid-frame: the current frame completes and no new frame starts.

## Timing
- Byte cost: 16*CLK_DIV+2 cycles.
- First init byte (first io_cs fall) occurs 3*STARTUP_WAIT cycles after rst deasserts.
- init_done rises 1 cycle after the GAP of AF, the same cycle IDLE is entered.
- Frame start: the LOAD of byte 21 occurs the cycle after refresh_req is sampled in IDLE.
- Frame length: (6+COLS*PAGES)*(16*CLK_DIV+2) cycles, plus 1 cycle to return to IDLE.
- frame_done pulses in the IDLE-entry cycle. With continuous=1, the next LOAD follows in the next cycle.
- The RAM read for data byte n is issued in the GAP of byte n-1, or in the GAP of the last window byte for n=0. Data is therefore registered before LOAD.
- rst asserted mid-byte: outputs return to reset values immediately and the partial byte is abandoned.

## Test plan
- Power-up with STARTUP_WAIT=4, CLK_DIV=2, COLS=4, PAGES=2 → io_reset is 1/0/1 for 4 cycles each. First SPI byte is 0xAE with dc=0, and each bit lasts 4 cycles.
- SPI monitor captures the init list → exactly 23 bytes; the 11th byte is 0x0F; init_done rises after 0xAF; busy falls.
- Write addresses 0..7 = 0x10..0x17, pulse refresh_req → command bytes 21 00 03 22 00 01, then data 10..17 with dc=1. frame_done pulses once.
- Two refresh_req pulses during a frame → exactly one extra frame, then IDLE.
- continuous=1 for 2.5 frames, then drop → 3 frames back-to-back, 3 frame_done pulses, no gap between them beyond 1 cycle.
- rst pulse mid-data phase → outputs return to reset values the same cycle and the power sequence reruns. The next frame still shows 10..17 (RAM retained).

Source files
------------

// File: rtl/oled_spi_driver.sv
// -----------------------------------------------------------------------------
// oled_spi_driver
//
// Drives an SSD1306-class OLED panel over a write-only 4-wire SPI link.
// After reset it runs the panel power/reset sequence and sends the fixed init
// command list. It then streams the internal frame RAM to the panel when a
// refresh is requested, or back-to-back while `continuous` is high. The host
// (game logic) draws into the frame RAM through a separate write port, and
// that port works in every state.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   io_sclk      SPI clock, idles high
//   io_sdin      SPI data, MSB first
//   io_cs        chip select, active low
//   io_dc        0 = command byte, 1 = data byte
//   io_reset     panel reset, active low
//   wr_en        frame RAM write strobe
//   wr_addr      frame RAM byte address (page*COLS + column)
//   wr_data      frame RAM byte (bit0 = top row of the page)
//   refresh_req  request one frame transfer
//   continuous   keep starting frames back-to-back while high
//   busy         FSM is not in IDLE
//   init_done    init list has been sent (sticky until reset)
//   frame_done   one-cycle pulse when a frame has been sent
//
// States
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   PWR_HI    | io_reset high for STARTUP_WAIT cycles
//   PWR_LO    | io_reset low for STARTUP_WAIT cycles
//   PWR_HI2   | io_reset high again for STARTUP_WAIT cycles
//   LOAD      | latch the next byte into the shifter, io_cs low
//   SEND      | shift 8 bits out, 2*CLK_DIV cycles per bit
//   GAP       | io_cs high for one cycle, issue the next RAM read
//   IDLE      | wait for refresh_req, pending or continuous
//
// The phase register says which byte source LOAD uses: the init list, the
// 6-byte address window, or the frame RAM.
// -----------------------------------------------------------------------------
module oled_spi_driver #(
    parameter int STARTUP_WAIT = 10000000,
    parameter int CLK_DIV      = 1,
    parameter int COLS         = 128,
    parameter int PAGES        = 8,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic              io_sclk,
    output logic              io_sdin,
    output logic              io_cs,
    output logic              io_dc,
    output logic              io_reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              refresh_req,
    input  logic              continuous,
    output logic              busy,
    output logic              init_done,
    output logic              frame_done
);

    localparam int FRAME_BYTES = COLS * PAGES;
    localparam int INIT_BYTES  = 23;
    localparam int WIN_BYTES   = 6;
    // The byte index must reach FRAME_BYTES and also cover the init list.
    localparam int IDX_W = (ADDR_W + 1 > 5) ? ADDR_W + 1 : 5;
    localparam int TMR_W = (STARTUP_WAIT > 1) ? $clog2(STARTUP_WAIT) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(STARTUP_WAIT - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_PWR_HI  = 3'd0,
        S_PWR_LO  = 3'd1,
        S_PWR_HI2 = 3'd2,
        S_LOAD    = 3'd3,
        S_SEND    = 3'd4,
        S_GAP     = 3'd5,
        S_IDLE    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PH_INIT = 2'd0,
        PH_WIN  = 2'd1,
        PH_DATA = 2'd2
    } phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         bit_q, bit_d;
    logic               sclk_q, sclk_d;
    logic [7:0]         shift_q, shift_d;
    logic               pending_q, pending_d;
    logic               init_done_q, init_done_d;
    logic               frame_done_q, frame_done_d;

    logic [7:0]         frame_ram [2**ADDR_W];
    logic [7:0]         rd_data_q;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic               ram_we;

    logic               tmr_tc;
    logic               div_tc;
    logic               last_byte;
    logic               frame_start;
    logic [IDX_W-1:0]   idx_nxt;
    logic [7:0]         load_byte;

    function automatic logic [7:0] init_byte(input logic [4:0] i);
        logic [7:0] b;
        case (i)
            5'd0:    b = 8'hAE;
            5'd1:    b = 8'h81;
            5'd2:    b = 8'h7F;
            5'd3:    b = 8'hA6;
            5'd4:    b = 8'h20;
            5'd5:    b = 8'h00;
            5'd6:    b = 8'hC8;
            5'd7:    b = 8'h40;
            5'd8:    b = 8'hA1;
            5'd9:    b = 8'hA8;
            5'd10:   b = 8'(PAGES * 8 - 1);
            5'd11:   b = 8'hD3;
            5'd12:   b = 8'h00;
            5'd13:   b = 8'hD5;
            5'd14:   b = 8'h80;
            5'd15:   b = 8'hD9;
            5'd16:   b = 8'h22;
            5'd17:   b = 8'hDB;
            5'd18:   b = 8'h20;
            5'd19:   b = 8'h8D;
            5'd20:   b = 8'h14;
            5'd21:   b = 8'hA4;
            5'd22:   b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Column range 0..COLS-1, page range 0..PAGES-1.
    function automatic logic [7:0] win_byte(input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = 8'h21;
            3'd1:    b = 8'h00;
            3'd2:    b = 8'(COLS - 1);
            3'd3:    b = 8'h22;
            3'd4:    b = 8'h00;
            3'd5:    b = 8'(PAGES - 1);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Frame RAM: one write port for the host, one read port for the
    // streamer. Non-blocking read and write on the same edge give
    // read-first behaviour on an address collision.
    // ------------------------------------------------------------------
    assign ram_we = wr_en && (IDX_W'(wr_addr) < IDX_W'(FRAME_BYTES));

    always_ff @(posedge clk) begin
        if (ram_we) begin
            frame_ram[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= frame_ram[rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    assign tmr_tc      = (tmr_q == '0);
    assign div_tc      = (div_q == '0);
    assign idx_nxt     = idx_q + IDX_W'(1);
    assign frame_start = (state_q == S_IDLE) && (refresh_req || pending_q || continuous);

    always_comb begin
        last_byte = 1'b0;
        case (phase_q)
            PH_INIT: last_byte = (idx_q == IDX_W'(INIT_BYTES - 1));
            PH_WIN:  last_byte = (idx_q == IDX_W'(WIN_BYTES - 1));
            PH_DATA: last_byte = (idx_q == IDX_W'(FRAME_BYTES - 1));
            default: last_byte = 1'b0;
        endcase
    end

    always_comb begin
        load_byte = rd_data_q;
        case (phase_q)
            PH_INIT: load_byte = init_byte(idx_q[4:0]);
            PH_WIN:  load_byte = win_byte(idx_q[2:0]);
            default: load_byte = rd_data_q;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 1: state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_PWR_HI;
            phase_q      <= PH_INIT;
            idx_q        <= '0;
            tmr_q        <= TMR_MAX;
            div_q        <= '0;
            bit_q        <= '0;
            sclk_q       <= 1'b1;
            shift_q      <= '0;
            pending_q    <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            tmr_q        <= tmr_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            sclk_q       <= sclk_d;
            shift_q      <= shift_d;
            pending_q    <= pending_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PWR_HI:  if (tmr_tc) state_d = S_PWR_LO;
            S_PWR_LO:  if (tmr_tc) state_d = S_PWR_HI2;
            S_PWR_HI2: if (tmr_tc) state_d = S_LOAD;
            S_LOAD:    state_d = S_SEND;
            S_SEND:    if (div_tc && sclk_q && (bit_q == 3'd0)) state_d = S_GAP;
            S_GAP: begin
                // The window flows straight into the data phase; the end of
                // the init list or of the data phase returns to IDLE.
                if (last_byte && (phase_q != PH_WIN)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_IDLE:    if (frame_start) state_d = S_LOAD;
            default:   state_d = S_PWR_HI;
        endcase
    end

    // Datapath updates that follow the state transitions above.
    always_comb begin
        phase_d      = phase_q;
        idx_d        = idx_q;
        tmr_d        = tmr_q;
        div_d        = div_q;
        bit_d        = bit_q;
        sclk_d       = sclk_q;
        shift_d      = shift_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = '0;

        // One level of pending; a frame start consumes it.
        pending_d = frame_start ? 1'b0 : (pending_q || (refresh_req && (state_q != S_IDLE)));

        case (state_q)
            S_PWR_HI, S_PWR_LO, S_PWR_HI2: begin
                tmr_d = tmr_tc ? TMR_MAX : (tmr_q - TMR_W'(1));
                if (tmr_tc && (state_q == S_PWR_HI2)) begin
                    phase_d = PH_INIT;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                shift_d = load_byte;
                div_d   = DIV_MAX;
                bit_d   = 3'd7;
                sclk_d  = 1'b0;
            end
            S_SEND: begin
                if (div_tc) begin
                    div_d = DIV_MAX;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q != 3'd0) begin
                        sclk_d  = 1'b0;
                        bit_d   = bit_q - 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            S_GAP: begin
                // Prefetch the next data byte so it is registered by LOAD:
                // address 0 after the last window byte, idx+1 during data.
                rd_en   = 1'b1;
                rd_addr = (phase_q == PH_DATA) ? idx_nxt[ADDR_W-1:0] : '0;
                if (last_byte) begin
                    idx_d = '0;
                    case (phase_q)
                        PH_INIT: init_done_d  = 1'b1;
                        PH_WIN:  phase_d      = PH_DATA;
                        default: frame_done_d = 1'b1;
                    endcase
                end else begin
                    idx_d = idx_nxt;
                end
            end
            S_IDLE: begin
                if (frame_start) begin
                    phase_d = PH_WIN;
                    idx_d   = '0;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        io_sclk  = 1'b1;
        io_sdin  = 1'b0;
        io_cs    = 1'b1;
        io_dc    = 1'b1;
        io_reset = 1'b1;
        busy     = 1'b1;
        case (state_q)
            S_PWR_LO: io_reset = 1'b0;
            S_LOAD: begin
                io_cs = 1'b0;
                io_dc = (phase_q == PH_DATA);
            end
            S_SEND: begin
                io_cs   = 1'b0;
                io_sclk = sclk_q;
                io_sdin = shift_q[7];
                io_dc   = (phase_q == PH_DATA);
            end
            S_GAP:  io_dc = (phase_q == PH_DATA);
            S_IDLE: busy  = 1'b0;
            default: ;
        endcase
    end

    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_oled_spi_driver.sv
// -----------------------------------------------------------------------------
// tb_oled_spi_driver
//
// Small panel geometry (4 columns x 2 pages), short power phases and a
// half-period of 2 clocks. An SPI monitor reassembles every byte and pops the
// matching {dc, byte} from a scoreboard queue filled when stimulus is issued.
// Table-driven vectors cover the power-up waveform and the RAM write port.
// -----------------------------------------------------------------------------
module tb_oled_spi_driver;

    localparam int SW       = 4;
    localparam int CD       = 2;
    localparam int COLS     = 4;
    localparam int PAGES    = 2;
    localparam int AW       = 4;
    localparam int NBYTES   = COLS * PAGES;
    localparam int BYTE_CYC = 16 * CD + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          io_sclk, io_sdin, io_cs, io_dc, io_reset;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          refresh_req = 1'b0;
    logic          continuous = 1'b0;
    logic          busy, init_done, frame_done;

    always #5 clk = ~clk;

    oled_spi_driver #(
        .STARTUP_WAIT (SW),
        .CLK_DIV      (CD),
        .COLS         (COLS),
        .PAGES        (PAGES),
        .ADDR_W       (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .io_sclk     (io_sclk),
        .io_sdin     (io_sdin),
        .io_cs       (io_cs),
        .io_dc       (io_dc),
        .io_reset    (io_reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .refresh_req (refresh_req),
        .continuous  (continuous),
        .busy        (busy),
        .init_done   (init_done),
        .frame_done  (frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int   cyc;
        logic exp_reset;
        logic exp_cs;
        logic exp_busy;
    } pwr_vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          accept;
    } wr_vec_t;

    pwr_vec_t   pwr_tbl [7];
    wr_vec_t    wr_tbl  [12];
    logic [7:0] init_list [23];
    logic [7:0] model_ram [NBYTES];
    logic [8:0] exp_q [$];

    // ------------------------------------------------------------------
    // SPI monitor and frame_done counter
    // ------------------------------------------------------------------
    int         bits = 0;
    int         cs_cnt = 0;
    int         rx_cnt = 0;
    int         fd_cnt = 0;
    logic [7:0] sh = '0;
    logic [8:0] exp_item;
    logic       prev_sclk = 1'b1;
    logic       prev_cs = 1'b1;
    logic       fd_prev = 1'b0;
    logic       cont_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            bits      = 0;
            cs_cnt    = 0;
            prev_sclk = 1'b1;
            prev_cs   = 1'b1;
            fd_prev   = 1'b0;
        end else begin
            if (!io_cs) cs_cnt++;
            if (!prev_sclk && io_sclk && !io_cs) begin
                sh = {sh[6:0], io_sdin};
                bits++;
                if (bits == 8) begin
                    bits = 0;
                    rx_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL spi_unexpected: got dc=%0b byte=0x%02h, expected no byte", io_dc, sh);
                    end else begin
                        exp_item = exp_q.pop_front();
                        check("spi_byte", 32'({io_dc, sh}), 32'(exp_item));
                    end
                end
            end
            if (io_cs && !prev_cs) begin
                check("cs_low_cycles", 32'(cs_cnt), 32'(16 * CD + 1));
                cs_cnt = 0;
            end
            if (fd_prev && cont_prev) check("b2b_next_load_cs", 32'(io_cs), 32'd0);
            if (frame_done) fd_cnt++;
            fd_prev   = frame_done;
            cont_prev = continuous;
            prev_sclk = io_sclk;
            prev_cs   = io_cs;
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic push_init();
        for (int i = 0; i < 23; i++) exp_q.push_back({1'b0, init_list[i]});
    endtask

    task automatic push_frame();
        exp_q.push_back({1'b0, 8'h21});
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'(COLS - 1)});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'(PAGES - 1)});
        for (int i = 0; i < NBYTES; i++) exp_q.push_back({1'b1, model_ram[i]});
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({io_sclk, io_sdin, io_cs, io_dc, io_reset, busy, init_done, frame_done}),
              32'(8'b1011_1100));
    endtask

    // Called right at the negedge where rst has just been released.
    task automatic run_pwr_table();
        int cur;
        cur = 0;
        for (int i = 0; i < 7; i++) begin
            repeat (pwr_tbl[i].cyc - cur) @(negedge clk);
            cur = pwr_tbl[i].cyc;
            check($sformatf("pwr_vec%0d", i), 32'({io_reset, io_cs, busy}),
                  32'({pwr_tbl[i].exp_reset, pwr_tbl[i].exp_cs, pwr_tbl[i].exp_busy}));
        end
    endtask

    task automatic wait_init(input int rx_base);
        for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk);
        check("init_done_rise", 32'(init_done), 32'd1);
        check("busy_low_at_init_done", 32'(busy), 32'd0);
        check("init_byte_count", 32'(rx_cnt - rx_base), 32'd23);
        check("init_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
    endtask

    task automatic wait_frames(input int base, input int n);
        for (int i = 0; i < 4000 && (fd_cnt < base + n); i++) @(negedge clk);
        repeat (100) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        int base;

        pwr_tbl[0] = '{0,  1'b1, 1'b1, 1'b1};
        pwr_tbl[1] = '{3,  1'b1, 1'b1, 1'b1};
        pwr_tbl[2] = '{4,  1'b0, 1'b1, 1'b1};
        pwr_tbl[3] = '{7,  1'b0, 1'b1, 1'b1};
        pwr_tbl[4] = '{8,  1'b1, 1'b1, 1'b1};
        pwr_tbl[5] = '{11, 1'b1, 1'b1, 1'b1};
        pwr_tbl[6] = '{12, 1'b1, 1'b0, 1'b1};

        wr_tbl[0]  = '{4'd0,  8'h10, 1'b1};
        wr_tbl[1]  = '{4'd1,  8'h11, 1'b1};
        wr_tbl[2]  = '{4'd2,  8'h99, 1'b1};
        wr_tbl[3]  = '{4'd2,  8'h12, 1'b1};
        wr_tbl[4]  = '{4'd3,  8'h13, 1'b1};
        wr_tbl[5]  = '{4'd8,  8'hEE, 1'b0};
        wr_tbl[6]  = '{4'd4,  8'h14, 1'b1};
        wr_tbl[7]  = '{4'd5,  8'h15, 1'b1};
        wr_tbl[8]  = '{4'd15, 8'h55, 1'b0};
        wr_tbl[9]  = '{4'd6,  8'h16, 1'b1};
        wr_tbl[10] = '{4'd7,  8'h17, 1'b1};
        wr_tbl[11] = '{4'd9,  8'hAA, 1'b0};

        init_list = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40,
                      8'hA1, 8'hA8, 8'h0F, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9,
                      8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};
        for (int i = 0; i < NBYTES; i++) model_ram[i] = 8'h00;

        // Reset state, power-up waveform, init list.
        #1;
        check_reset_outputs("reset_values");
        repeat (3) @(negedge clk);
        push_init();
        rst = 1'b0;
        run_pwr_table();

        // RAM writes while init is still streaming.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = wr_tbl[i].addr;
            wr_data = wr_tbl[i].data;
            if (wr_tbl[i].accept) model_ram[int'(wr_tbl[i].addr)] = wr_tbl[i].data;
        end
        @(negedge clk);
        wr_en = 1'b0;
        wait_init(0);

        // Single frame: start latency, length, pulse width.
        push_frame();
        base = fd_cnt;
        @(negedge clk);
        refresh_req = 1'b1;
        @(posedge clk);
        #1;
        refresh_req = 1'b0;
        check("frame_start_load", 32'({io_cs, io_dc}), 32'd0);
        n = 0;
        while (!frame_done && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("frame_latency", 32'(n), 32'((6 + NBYTES) * BYTE_CYC));
        check("busy_low_at_frame_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("frame_done_one_cycle", 32'(frame_done), 32'd0);
        repeat (20) @(negedge clk);
        check("frame1_queue_drained", 32'(exp_q.size()), 32'd0);
        check("frame1_done_count", 32'(fd_cnt - base), 32'd1);

        // Two requests during a frame merge into one extra frame.
        base = fd_cnt;
        push_frame();
        push_frame();
        pulse_refresh();
        repeat (100) @(negedge clk);
        pulse_refresh();
        repeat (60) @(negedge clk);
        pulse_refresh();
        wait_frames(base, 2);
        check("pending_frame_count", 32'(fd_cnt - base), 32'd2);
        check("pending_idle_after", 32'(busy), 32'd0);
        check("pending_queue_drained", 32'(exp_q.size()), 32'd0);

        // Continuous for about 2.5 frames.
        base = fd_cnt;
        push_frame();
        push_frame();
        push_frame();
        @(negedge clk);
        continuous = 1'b1;
        repeat (((6 + NBYTES) * BYTE_CYC + 1) * 5 / 2) @(negedge clk);
        continuous = 1'b0;
        wait_frames(base, 3);
        check("continuous_frame_count", 32'(fd_cnt - base), 32'd3);
        check("continuous_idle_after", 32'(busy), 32'd0);
        check("continuous_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of the data phase.
        push_frame();
        pulse_refresh();
        repeat (300) @(negedge clk);
        check("mid_data_before_reset", 32'({busy, io_dc}), 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_values_mid_data");
        exp_q.delete();
        push_init();
        repeat (2) @(negedge clk);
        base = rx_cnt;
        rst = 1'b0;
        run_pwr_table();
        wait_init(base);
        base = fd_cnt;
        push_frame();
        pulse_refresh();
        wait_frames(base, 1);
        check("after_reset_frame_count", 32'(fd_cnt - base), 32'd1);
        check("after_reset_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
